pipe_ctrl_gen: RTL and testbench

Parametrised pipeline stall/flush controller for the dual-issue core. It generalises fixed per-register control to NSTAGE pipeline registers and NSRC stall sources, each source bound to a stage. It adds three sequential features: latched deferred flushes, a post-exception redirect sequence, and saturating stall/exception event counters. It sits beside the datapath and drives the stall/flush pins of every pipeline register plus the PC unit.

---
 rtl/pipe_ctrl_gen.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: stall/flush controller for NSTAGE pipeline registers.
// Combinational stall/flush decision from the live requests, plus latched
// deferred flushes, a post-exception redirect sequence and event counters.
module pipe_ctrl_gen #(
  parameter int unsigned        NSTAGE       = 6,
  parameter int unsigned        NSRC         = 4,
  parameter logic [NSRC*4-1:0]  SRC_STAGE    = '0,
  parameter int unsigned        REDIRECT_CYC = 2,
  parameter int unsigned        CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   stall_req,
  input  logic [NSTAGE-1:0] flush_req,
  input  logic              exc_flush,
  input  logic              mem_refetch,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic              busy_redirect,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  exc_cnt
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t            state;
  logic [3:0]        rcnt;
  logic [NSTAGE-1:0] pend;
  logic [NSTAGE-1:0] pend_nxt;
  logic              x;
  logic              s_vld;
  logic [3:0]        s_idx;
  logic [NSTAGE-1:0] freq_eff;
  logic [NSTAGE-1:0] fmask;
  logic [NSTAGE-1:0] stall_c;
  logic [NSTAGE-1:0] flush_c;

  assign x             = exc_flush | mem_refetch;
  assign busy_redirect = (state == REDIRECT);

  // Oldest register index stalled by any active source.
  always_comb begin
    s_vld = 1'b0;
    s_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (stall_req[i] && (!s_vld || SRC_STAGE[i*4 +: 4] > s_idx)) begin
        s_vld = 1'b1;
        s_idx = SRC_STAGE[i*4 +: 4];
      end
    end
  end

  // Stall/flush decision; flushes younger than the stall point are deferred.
  always_comb begin
    freq_eff    = flush_req | pend;
    freq_eff[0] = 1'b0;
    fmask       = '0;
    pend_nxt    = '0;
    stall_c     = '0;
    flush_c     = '0;
    for (int unsigned j = 0; j < NSTAGE; j++) begin
      if (s_vld && j <= 32'(s_idx))
        stall_c[j] = 1'b1;
      if (s_vld && j == 32'(s_idx) + 1)
        flush_c[j] = 1'b1;
    end
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      if (freq_eff[k]) begin
        if (!s_vld || 32'(s_idx) < k) begin
          for (int unsigned j = 0; j < k; j++)
            fmask[j] = 1'b1;
        end else begin
          pend_nxt[k] = 1'b1;
        end
      end
    end
    stall_c = stall_c & ~fmask;
    flush_c = flush_c | fmask;
    if (state == REDIRECT)
      flush_c[0] = 1'b1;

    if (rst) begin
      stall_o     = '0;
      flush_o     = '1;
      pc_stall    = 1'b0;
      pc_redirect = 1'b0;
    end else if (x) begin
      stall_o     = '0;
      flush_o     = '1;
      pc_stall    = 1'b0;
      pc_redirect = 1'b1;
    end else begin
      stall_o     = stall_c;
      flush_o     = flush_c;
      pc_stall    = s_vld;
      pc_redirect = 1'b0;
    end
  end

  // Redirect sequencer and pending-flush latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      pend  <= '0;
    end else if (x) begin
      state <= REDIRECT;
      rcnt  <= 4'(REDIRECT_CYC - 1);
      pend  <= '0;
    end else begin
      pend <= pend_nxt;
      if (state == REDIRECT) begin
        if (rcnt == 4'd0)
          state <= IDLE;
        else
          rcnt <= rcnt - 4'd1;
      end
    end
  end

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      exc_cnt   <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      exc_cnt   <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (x && exc_cnt != '1)
        exc_cnt <= exc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Testbench for pipe_ctrl_gen: vector table, directed sequences, random vs model.
module tb_pipe_ctrl_gen;

  localparam int unsigned NS = 6;
  localparam logic [15:0] SRCS = 16'h3210;
  localparam int unsigned RC = 2;
  localparam int unsigned CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    stall_req;
  logic [NS-1:0] flush_req;
  logic          exc_flush, mem_refetch, cnt_clr;
  logic [NS-1:0] stall_o, flush_o;
  logic          pc_stall, pc_redirect, busy_redirect;
  logic [1:0]    stall_cnt, exc_cnt;

  int checks = 0;
  int failures = 0;

  pipe_ctrl_gen #(.NSTAGE(NS), .NSRC(4), .SRC_STAGE(SRCS), .REDIRECT_CYC(RC), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .exc_flush(exc_flush), .mem_refetch(mem_refetch), .cnt_clr(cnt_clr),
    .stall_o(stall_o), .flush_o(flush_o), .pc_stall(pc_stall),
    .pc_redirect(pc_redirect), .busy_redirect(busy_redirect),
    .stall_cnt(stall_cnt), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [5:0] st, input logic [5:0] fl,
                            input logic pcs, input logic pcr, input logic bsy);
    chk({tag, ".stall_o"}, 32'(stall_o), 32'(st));
    chk({tag, ".flush_o"}, 32'(flush_o), 32'(fl));
    chk({tag, ".pc_stall"}, 32'(pc_stall), 32'(pcs));
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(pcr));
    chk({tag, ".busy"}, 32'(busy_redirect), 32'(bsy));
  endtask

  task automatic drive(input logic [3:0] sr, input logic [5:0] fr, input logic e,
                       input logic m, input logic c);
    stall_req = sr; flush_req = fr; exc_flush = e; mem_refetch = m; cnt_clr = c;
  endtask

  // Next cycle: wait for the falling edge, apply inputs, let them settle.
  task automatic nxt(input logic [3:0] sr, input logic [5:0] fr, input logic e,
                     input logic m, input logic c);
    @(negedge clk);
    drive(sr, fr, e, m, c);
    #1;
  endtask

  typedef struct {
    logic [3:0] sr;
    logic [5:0] fr;
    logic [5:0] st;
    logic [5:0] fl;
    logic       pcs;
  } vec_t;
  vec_t tbl[12];

  // Reference model state
  bit [NS-1:0] m_pend;
  int          m_rem;
  int          m_scnt, m_ecnt;

  initial begin
    rst = 1'b1;
    drive(4'b0, 6'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    expect_ctl("reset", 6'h00, 6'h3f, 1'b0, 1'b0, 1'b0);
    chk("reset.stall_cnt", 32'(stall_cnt), 0);
    chk("reset.exc_cnt", 32'(exc_cnt), 0);
    rst = 1'b0;

    // Single source stall, counter ramp to saturation
    nxt(4'b0100, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("stall2.c0", 6'h07, 6'h08, 1'b1, 1'b0, 1'b0);
    chk("stall2.cnt0", 32'(stall_cnt), 0);
    nxt(4'b0100, 6'b0, 1'b0, 1'b0, 1'b0);
    chk("stall2.cnt1", 32'(stall_cnt), 1);
    nxt(4'b0100, 6'b0, 1'b0, 1'b0, 1'b0);
    chk("stall2.cnt2", 32'(stall_cnt), 2);
    nxt(4'b0000, 6'b010000, 1'b0, 1'b0, 1'b0);
    expect_ctl("flush4", 6'h00, 6'h0f, 1'b0, 1'b0, 1'b0);
    chk("stall2.cnt3", 32'(stall_cnt), 3);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("flush4.after", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);

    // Deferred flush behind a stage-3 stall
    nxt(4'b1000, 6'b000100, 1'b0, 1'b0, 1'b0);
    expect_ctl("defer.c0", 6'h0f, 6'h10, 1'b1, 1'b0, 1'b0);
    nxt(4'b1000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("defer.c1", 6'h0f, 6'h10, 1'b1, 1'b0, 1'b0);
    nxt(4'b1000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("defer.c2", 6'h0f, 6'h10, 1'b1, 1'b0, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("defer.release", 6'h00, 6'h03, 1'b0, 1'b0, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("defer.done", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("sat.stall_cnt", 32'(stall_cnt), 3);

    // Clear beats increment
    nxt(4'b0001, 6'b0, 1'b0, 1'b0, 1'b1);
    expect_ctl("clr.c0", 6'h01, 6'h02, 1'b1, 1'b0, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    chk("clr.stall_cnt", 32'(stall_cnt), 0);
    chk("clr.exc_cnt", 32'(exc_cnt), 0);

    // Exception during a stall, then redirect sequence
    nxt(4'b1000, 6'b0, 1'b1, 1'b0, 1'b0);
    expect_ctl("exc.c0", 6'h00, 6'h3f, 1'b0, 1'b1, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("exc.c1", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    chk("exc.exc_cnt", 32'(exc_cnt), 1);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("exc.c2", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("exc.c3", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("exc.stall_cnt", 32'(stall_cnt), 0);

    // Refetch on second redirect cycle restarts the sequence
    nxt(4'b0000, 6'b0, 1'b1, 1'b0, 1'b0);
    expect_ctl("rf.c0", 6'h00, 6'h3f, 1'b0, 1'b1, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("rf.c1", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    nxt(4'b0000, 6'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl("rf.c2", 6'h00, 6'h3f, 1'b0, 1'b1, 1'b1);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("rf.c3", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    chk("rf.exc_cnt", 32'(exc_cnt), 3);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("rf.c4", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("rf.c5", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a redirect
    nxt(4'b0000, 6'b0, 1'b1, 1'b0, 1'b0);
    nxt(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    expect_ctl("rstmid.pre", 6'h00, 6'h01, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    expect_ctl("rstmid.in", 6'h00, 6'h3f, 1'b0, 1'b0, 1'b0);
    chk("rstmid.exc_cnt", 32'(exc_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_ctl("rstmid.post", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0);

    // Combinational vector table, each from a fresh reset with no clock edge
    tbl[0]  = '{4'b0001, 6'b000000, 6'h01, 6'h02, 1'b1};
    tbl[1]  = '{4'b0100, 6'b000000, 6'h07, 6'h08, 1'b1};
    tbl[2]  = '{4'b1000, 6'b000000, 6'h0f, 6'h10, 1'b1};
    tbl[3]  = '{4'b1111, 6'b000000, 6'h0f, 6'h10, 1'b1};
    tbl[4]  = '{4'b0000, 6'b000010, 6'h00, 6'h01, 1'b0};
    tbl[5]  = '{4'b0000, 6'b000001, 6'h00, 6'h00, 1'b0};
    tbl[6]  = '{4'b0000, 6'b100000, 6'h00, 6'h1f, 1'b0};
    tbl[7]  = '{4'b0001, 6'b000100, 6'h00, 6'h03, 1'b1};
    tbl[8]  = '{4'b1000, 6'b100000, 6'h00, 6'h1f, 1'b1};
    tbl[9]  = '{4'b0010, 6'b000110, 6'h00, 6'h07, 1'b1};
    tbl[10] = '{4'b1000, 6'b001000, 6'h0f, 6'h10, 1'b1};
    tbl[11] = '{4'b0000, 6'b000000, 6'h00, 6'h00, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      drive(tbl[i].sr, tbl[i].fr, 1'b0, 1'b0, 1'b0);
      #1;
      expect_ctl($sformatf("tbl%0d", i), tbl[i].st, tbl[i].fl, tbl[i].pcs, 1'b0, 1'b0);
      #1 drive(4'b0, 6'b0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized run against the behavioural model
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    m_pend = '0; m_rem = 0; m_scnt = 0; m_ecnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, e, m, c, xx;
      logic [3:0] sr;
      logic [5:0] fr;
      int s, kmax;
      bit [5:0] fmask, exp_st, exp_fl;
      bit [NS-1:0] pn;
      @(negedge clk);
      r  = ($urandom_range(0, 199) == 0);
      sr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      fr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      e  = ($urandom_range(0, 24) == 0);
      m  = ($urandom_range(0, 24) == 0);
      c  = ($urandom_range(0, 29) == 0);
      rst = r;
      drive(sr, fr, e, m, c);
      #1;
      if (r) begin
        m_pend = '0; m_rem = 0; m_scnt = 0; m_ecnt = 0;
        expect_ctl("rnd.rst", 6'h00, 6'h3f, 1'b0, 1'b0, 1'b0);
        chk("rnd.rst.stall_cnt", 32'(stall_cnt), 0);
        chk("rnd.rst.exc_cnt", 32'(exc_cnt), 0);
        continue;
      end
      xx = e | m;
      s = -1;
      for (int i = 0; i < 4; i++)
        if (sr[i] && int'(SRCS[i*4 +: 4]) > s) s = int'(SRCS[i*4 +: 4]);
      kmax = 0;
      pn = '0;
      for (int k = 1; k < NS; k++) begin
        if (fr[k] || m_pend[k]) begin
          if (s < k) kmax = (k > kmax) ? k : kmax;
          else pn[k] = 1'b1;
        end
      end
      fmask  = 6'((1 << kmax) - 1);
      exp_st = (s >= 0) ? 6'((1 << (s + 1)) - 1) & ~fmask : 6'h00;
      exp_fl = fmask | ((s >= 0 && s + 1 < NS) ? 6'(1 << (s + 1)) : 6'h00)
                     | ((m_rem > 0) ? 6'h01 : 6'h00);
      if (xx) begin
        exp_st = 6'h00;
        exp_fl = 6'h3f;
      end
      expect_ctl("rnd", exp_st, exp_fl, !xx && s >= 0, xx, m_rem > 0);
      chk("rnd.stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk("rnd.exc_cnt", 32'(exc_cnt), 32'(m_ecnt));
      // advance model to the next cycle
      if (c) begin
        m_scnt = 0; m_ecnt = 0;
      end else begin
        if (!xx && s >= 0 && m_scnt < CMAX) m_scnt++;
        if (xx && m_ecnt < CMAX) m_ecnt++;
      end
      if (xx) begin
        m_pend = '0;
        m_rem = RC;
      end else begin
        m_pend = pn;
        if (m_rem > 0) m_rem--;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
